// File: rtl/fetch_ctrl.sv
// fetch_ctrl: AXI read-burst instruction fetch controller with branch redirect and drain.
// Optional FETCH_RRESP_CHECK_EN enables a sticky read-error flag that blocks fetching until a redirect.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BURST_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        buf_full,
    input  logic        arready,
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    input  logic        rready,
    input  logic        rlast,
    input  logic [1:0]  rresp,
    output logic [31:0] fetch_pc,
    output logic        jump_wait,
    output logic        jump_accept,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    localparam logic [31:0] BURST_BYTES = 32'(BURST_BEATS) << 3;

    state_t      state;
    logic [31:0] pc_next, tgt;
    logic        wait_q, acc_q, beat, drain_done;

    assign beat       = rvalid & rready;
    assign drain_done = (state == DRAIN) && beat && rlast;
    // A drain redirect is announced on the rlast beat itself so the buffer flushes that stale beat too.
    assign jump_accept = acc_q | drain_done;
    assign jump_wait   = wait_q & ~drain_done;
    assign arlen       = 8'(BURST_BEATS - 1);
    assign arsize      = 3'b011;
    assign arburst     = 2'b01;

`ifdef FETCH_RRESP_CHECK_EN
    logic unused_rresp;
    assign unused_rresp = 1'b0;
    always_ff @(posedge clk) begin
        if (rst)
            fetch_err <= 1'b0;
        else if (jump_accept)
            fetch_err <= 1'b0;
        else if (beat && rresp != 2'b00 && (state == DATA || state == DRAIN))
            fetch_err <= 1'b1;
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign fetch_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc_next  <= RESET_PC;
            fetch_pc <= RESET_PC;
            arvalid  <= 1'b0;
            araddr   <= RESET_PC & ~32'h7;
            tgt      <= '0;
            wait_q   <= 1'b0;
            acc_q    <= 1'b0;
        end else begin
            acc_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (jump) begin
                        pc_next <= jump_target;
                        acc_q   <= 1'b1;
                    end else if (!buf_full && !fetch_err) begin
                        arvalid <= 1'b1;
                        araddr  <= pc_next & ~32'h7;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (jump) begin
                        tgt    <= jump_target;
                        wait_q <= 1'b1;
                    end
                    if (arready) begin
                        arvalid  <= 1'b0;
                        fetch_pc <= araddr;
                        state    <= (jump || wait_q) ? DRAIN : DATA;
                    end
                end
                DATA: begin
                    if (beat)
                        fetch_pc <= fetch_pc + 32'd8;
                    if (beat && rlast) begin
                        // A jump on the final beat redirects straight from IDLE, no drain needed.
                        pc_next <= jump ? jump_target : araddr + BURST_BYTES;
                        acc_q   <= jump;
                        state   <= IDLE;
                    end else if (jump) begin
                        tgt    <= jump_target;
                        wait_q <= 1'b1;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (beat)
                        fetch_pc <= fetch_pc + 32'd8;
                    if (jump)
                        tgt <= jump_target;
                    if (beat && rlast) begin
                        pc_next <= jump ? jump_target : tgt;
                        wait_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
